apple1_pia: RTL and testbench
=============================

# apple1_pia

Register-compatible keyboard/display port block for the Apple-1 core, decoded at 0xD010–0xD013. It sits between the character sources (PS/2 decoder, UART RX, text loader) and the CPU data bus on the input side, and between the CPU and the display consumers (VGA text engine, UART TX) on the output side. It buffers typed keys in a small FIFO and runs a busy/acknowledge handshake for display characters, so WozMon polling loops behave as on the original 6820 PIA.

## Interface
- FIFO_DEPTH_LOG2, 3, key FIFO depth is 2^N entries (N ≥ 1).
- DSP_TIMEOUT, 4096, clk25 cycles to wait for `dsp_ack` before busy self-clears (≥ 2).

Ports:
- clk25  in  1  master clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  CPU clock enable (cpu_clken); register side effects only when high.
- cs  in  1  chip select for 0xD010–0xD013.
- address  in  2  register index (ab[1:0]).
- w_en  in  1  CPU write strobe.
- din  in  8  CPU write data.
- dout  out  8  CPU read data, combinational from `address` and state.
- key_valid  in  1  source has a character.
- key_data  in  7  ASCII character from the source.
- key_ready  out  1  FIFO can accept a character (= !full).
- dsp_valid  out  1  display character pending.
- dsp_data  out  7  display character.
- dsp_ack  in  1  consumer took `dsp_data`.

## Operation
- Key push: a key is pushed when `key_valid & key_ready` is true on a clk25 edge. The push does not depend on `enable`.
- Key pop: "read strobe" = `enable & cs & ~w_en`. A read strobe at address 0 with the FIFO nonempty pops the head. The popped value is copied to `last_key`.
- Registers:
  - Addr 0 (KBD) read: `{1, head}` if nonempty, else `{0, last_key}`. Writes are ignored.
  - Addr 1 (KBDCR) read: `{nonempty, kbd_ctrl[6:0]}`. A write stores `din[6:0]` into `kbd_ctrl`.
  - Addr 2 (DSP) read: `{busy, dsp_data}`.
  - Addr 2 (DSP) write while idle: latches `din[6:0]` into `dsp_data` and sets busy and `dsp_valid`.
  - Addr 2 (DSP) write while busy: data is dropped and sticky `drop` is set.
  - Addr 3 (DSPCR) read: `{busy, drop, dsp_ctrl[5:0]}`.
  - Addr 3 (DSPCR) write: stores `din[5:0]`. `din[6]=1` clears `drop`.
- Display state machine:
  - States: IDLE, PEND. `busy` = (state == PEND).
  - IDLE → PEND on a DSP write.
  - PEND → IDLE on `dsp_ack`, or when the timeout counter reaches DSP_TIMEOUT−1.
  - The timeout counter clears when PEND is entered and counts every clk25 cycle while in PEND.
  - `dsp_valid` = busy.
- FIFO:
  - Circular buffer with read/write pointers and a count of width FIFO_DEPTH_LOG2+1.
  - Pointers wrap modulo depth.
- Boundary conditions:
  - Push and pop in the same cycle, FIFO nonempty and not full: both happen, count unchanged.
  - FIFO full: `key_ready`=0, so no push; a pop in that cycle still proceeds.
  - FIFO empty: a read pops nothing and count stays 0.
  - `dsp_ack` in the same cycle as a DSP write while IDLE: the write wins and the state becomes PEND.
  - `dsp_ack` while IDLE: ignored.
  - `rst` mid-transfer: `dsp_valid` drops immediately and the FIFO contents are discarded.
- Reset values:
  - FIFO empty; `key_ready`=1.
  - `last_key`=0, `dsp_data`=0, `kbd_ctrl`=0, `dsp_ctrl`=0, `drop`=0.
  - State IDLE, `dsp_valid`=0, so `dout`=0x00 at every address.

## Timing
- Key pushed at edge N: KBDCR bit7 reads 1 combinationally after edge N.
- Pop at edge N: the next entry, or the empty view, is visible after edge N. A CPU read sees the pre-pop head during the strobe cycle.
- DSP write at edge N: `dsp_valid`=1 after edge N.
- `dsp_ack` high at edge M: `dsp_valid`=0 and busy=0 after edge M. The minimum busy time is 1 cycle.
- Without an ack, busy clears exactly DSP_TIMEOUT cycles after the write edge.
- `key_ready` is registered-state derived, with no combinational path from `key_valid`.

## Configuration
- `APPLE1_PIA_UPCASE_EN` defined: `key_data` in 0x61–0x7A is stored as value−0x20; all other codes pass unchanged.
- Macro undefined: `key_data` is stored verbatim.

## Test plan
- Reset, then read addr 0–3 → all 0x00; `key_ready`=1, `dsp_valid`=0.
- Push 0x41, read KBDCR → 0x80; read KBD → 0xC1. A second KBDCR read → 0x00, and KBD → 0x41.
- Push 9 keys with depth 8 → `key_ready`=0 after the 8th and the 9th is not stored. Pop 8 reads them back in order; pointers wrap correctly on refill.
- Write DSP 0x8D → `dsp_valid`=1, `dsp_data`=0x0D, DSP read → 0x8D.
  - A second write 0x41 while busy → `drop`=1, DSPCR bit6 set, `dsp_data` unchanged.
  - `dsp_ack` → busy clears the next cycle.
- Write DSP with `dsp_ack` held low and DSP_TIMEOUT=16 → busy is 1 for exactly 16 cycles, then 0.
- With `APPLE1_PIA_UPCASE_EN`, push 0x61 → KBD reads 0xC1. Without the macro → KBD reads 0xE1.

Source files
------------

// File: rtl/apple1_pia.sv
// apple1_pia - Apple-1 keyboard/display port block (6820 PIA register view)
//
// Decoded at 0xD010-0xD013. Typed characters from any source (PS/2, UART RX,
// text loader) are buffered in a small key FIFO that the CPU drains through
// KBD/KBDCR. Display characters written to DSP are held with a busy flag
// until a consumer acknowledges them or a timeout expires, so WozMon's
// polling loops see the same handshake as on the original PIA.
//
// Parameters:
//   FIFO_DEPTH_LOG2 - key FIFO depth is 2**FIFO_DEPTH_LOG2 entries (>= 1)
//   DSP_TIMEOUT     - clk25 cycles to wait for dsp_ack before busy self-clears (>= 2)
//
// Ports:
//   clk25      in   master clock, all state on rising edge
//   rst        in   asynchronous, active-high reset
//   enable     in   CPU clock enable; register side effects only when high
//   cs         in   chip select for 0xD010-0xD013
//   address    in   [1:0] register index: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
//   w_en       in   CPU write strobe
//   din        in   [7:0] CPU write data
//   dout       out  [7:0] CPU read data (combinational)
//   key_valid  in   source has a character
//   key_data   in   [6:0] ASCII character from the source
//   key_ready  out  FIFO can accept a character (not full)
//   dsp_valid  out  display character pending (busy)
//   dsp_data   out  [6:0] display character
//   dsp_ack    in   consumer took dsp_data
//
// Build option:
//   APPLE1_PIA_UPCASE_EN - when defined, lower-case keys 0x61-0x7A are stored
//                          as upper case; otherwise keys are stored verbatim.

module apple1_pia #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int DSP_TIMEOUT     = 4096
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       cs,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       key_valid,
  input  logic [6:0] key_data,
  output logic       key_ready,
  output logic       dsp_valid,
  output logic [6:0] dsp_data,
  input  logic       dsp_ack
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(DSP_TIMEOUT);

  localparam logic [1:0] ADDR_KBD   = 2'd0;
  localparam logic [1:0] ADDR_KBDCR = 2'd1;
  localparam logic [1:0] ADDR_DSP   = 2'd2;
  localparam logic [1:0] ADDR_DSPCR = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } dsp_state_t;

  // ---------------------------------------------------------------------------
  // CPU strobes
  // ---------------------------------------------------------------------------
  logic rd_stb;
  logic wr_stb;

  assign rd_stb = enable & cs & ~w_en;
  assign wr_stb = enable & cs & w_en;

  // din[7] has no meaning in any register.
  logic unused_din7;
  assign unused_din7 = din[7];

  // ---------------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------------
  logic [6:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       nonempty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic [6:0]                 head;
  logic [6:0]                 key_in;
  logic [6:0]                 last_key;

  assign nonempty  = (count != '0);
  assign full      = (count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign key_ready = ~full;
  assign push      = key_valid & key_ready;
  assign pop       = rd_stb & (address == ADDR_KBD) & nonempty;
  assign head      = fifo_mem[rd_ptr];

  always_comb begin
    key_in = key_data;
`ifdef APPLE1_PIA_UPCASE_EN
    if (key_data >= 7'h61 && key_data <= 7'h7A) begin
      key_in = key_data - 7'h20;
    end
`endif
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk25) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_in;
    end
  end

  // Pointers are exactly FIFO_DEPTH_LOG2 bits wide, so they wrap modulo depth
  // by natural overflow.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_key <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_key <= head;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display handshake FSM
  // ---------------------------------------------------------------------------
  dsp_state_t      state;
  dsp_state_t      state_next;
  logic [TW-1:0]   timer;
  logic            busy;
  logic            dsp_wr;
  logic            drop;
  logic [6:0]      kbd_ctrl;
  logic [5:0]      dsp_ctrl;

  assign busy      = (state == PEND);
  assign dsp_valid = busy;
  assign dsp_wr    = wr_stb & (address == ADDR_DSP);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      state <= state_next;
    end
  end

  // A write while IDLE always wins over a coincident ack; an ack while IDLE
  // is simply ignored.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE: if (dsp_wr) state_next = PEND;
      PEND: if (dsp_ack || timer == TW'(DSP_TIMEOUT - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Held at zero while IDLE, so it starts from zero on entry to PEND and the
  // busy window is exactly DSP_TIMEOUT cycles when no ack arrives.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU-written registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      dsp_data <= '0;
      drop     <= 1'b0;
      kbd_ctrl <= '0;
      dsp_ctrl <= '0;
    end else if (wr_stb) begin
      case (address)
        ADDR_KBDCR: kbd_ctrl <= din[6:0];
        ADDR_DSP: begin
          if (busy) begin
            drop <= 1'b1;
          end else begin
            dsp_data <= din[6:0];
          end
        end
        ADDR_DSPCR: begin
          dsp_ctrl <= din[5:0];
          if (din[6]) begin
            drop <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: shows pre-pop state during a popping strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = 8'h00;
    case (address)
      ADDR_KBD:   dout = nonempty ? {1'b1, head} : {1'b0, last_key};
      ADDR_KBDCR: dout = {nonempty, kbd_ctrl};
      ADDR_DSP:   dout = {busy, dsp_data};
      ADDR_DSPCR: dout = {busy, drop, dsp_ctrl};
      default:    dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_apple1_pia.sv
// tb_apple1_pia - directed self-checking bench for apple1_pia.
// Inputs change 1 ns after the rising edge; outputs are sampled before the
// next rising edge. DSP_TIMEOUT is shortened to 16 so the timeout window can
// be measured directly.

module tb_apple1_pia;

  localparam int LOG2 = 3;
  localparam int TOUT = 16;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       enable;
  logic       cs;
  logic [1:0] address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       key_valid;
  logic [6:0] key_data;
  logic       key_ready;
  logic       dsp_valid;
  logic [6:0] dsp_data;
  logic       dsp_ack;

  int n_checks = 0;
  int n_fail   = 0;

  apple1_pia #(
    .FIFO_DEPTH_LOG2(LOG2),
    .DSP_TIMEOUT    (TOUT)
  ) dut (
    .clk25    (clk25),
    .rst      (rst),
    .enable   (enable),
    .cs       (cs),
    .address  (address),
    .w_en     (w_en),
    .din      (din),
    .dout     (dout),
    .key_valid(key_valid),
    .key_data (key_data),
    .key_ready(key_ready),
    .dsp_valid(dsp_valid),
    .dsp_data (dsp_data),
    .dsp_ack  (dsp_ack)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  // Combinational look at a register without a strobe.
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    enable  = 1'b0;
    cs      = 1'b0;
    address = a;
    #1;
    d = dout;
  endtask

  // One-cycle CPU read; returns the value visible during the strobe cycle.
  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    enable  = 1'b1;
    cs      = 1'b1;
    w_en    = 1'b0;
    address = a;
    #1;
    d = dout;
    tick();
    enable = 1'b0;
    cs     = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    enable  = 1'b1;
    cs      = 1'b1;
    w_en    = 1'b1;
    address = a;
    din     = d;
    tick();
    enable = 1'b0;
    cs     = 1'b0;
    w_en   = 1'b0;
  endtask

  task automatic push_key(input logic [6:0] k);
    key_valid = 1'b1;
    key_data  = k;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int cnt;

    rst = 1'b1; enable = 1'b0; cs = 1'b0; address = 2'd0; w_en = 1'b0;
    din = 8'h00; key_valid = 1'b0; key_data = 7'h00; dsp_ack = 1'b0;
    repeat (3) @(posedge clk25);
    #1 rst = 1'b0;
    tick();

    // Reset state
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), d);
      check($sformatf("reset_dout_a%0d", a), d, 8'h00);
    end
    check("reset_key_ready", {7'd0, key_ready}, 8'h01);
    check("reset_dsp_valid", {7'd0, dsp_valid}, 8'h00);

    // Single key: status, pop, empty view
    push_key(7'h41);
    cpu_read(2'd1, d); check("kbdcr_full", d, 8'h80);
    cpu_read(2'd0, d); check("kbd_pop", d, 8'hC1);
    cpu_read(2'd1, d); check("kbdcr_empty", d, 8'h00);
    cpu_read(2'd0, d); check("kbd_last", d, 8'h41);
    cpu_read(2'd0, d); check("kbd_empty_again", d, 8'h41);
    peek(2'd1, d);     check("count_stays_0", d, 8'h00);

    // Fill to depth 8 (write pointer starts at 1, so it wraps)
    for (int i = 0; i < 8; i++) push_key(7'(8'h30 + i));
    check("full_key_ready", {7'd0, key_ready}, 8'h00);
    push_key(7'h38);   // rejected: full
    check("still_full", {7'd0, key_ready}, 8'h00);
    // Pop while a push is offered against a full FIFO: pop proceeds, no push
    key_valid = 1'b1;
    key_data  = 7'h39;
    cpu_read(2'd0, d);
    key_valid = 1'b0;
    check("full_pop", d, 8'hB0);
    check("ready_after_pop", {7'd0, key_ready}, 8'h01);
    for (int i = 1; i < 8; i++) begin
      cpu_read(2'd0, d);
      check($sformatf("fifo_order_%0d", i), d, 8'(8'hB0 + i));
    end
    peek(2'd0, d); check("drained_last", d, 8'h37);
    peek(2'd1, d); check("drained_status", d, 8'h00);

    // Refill after wrap, then push and pop in the same cycle
    push_key(7'h52);
    key_valid = 1'b1;
    key_data  = 7'h53;
    cpu_read(2'd0, d);
    key_valid = 1'b0;
    check("pushpop_read", d, 8'hD2);
    peek(2'd0, d); check("pushpop_head", d, 8'hD3);
    cpu_read(2'd0, d); check("pushpop_pop", d, 8'hD3);
    peek(2'd1, d); check("pushpop_count", d, 8'h00);

    // KBDCR control bits
    cpu_write(2'd1, 8'hA5);
    peek(2'd1, d); check("kbdcr_ctrl", d, 8'h25);
    cpu_write(2'd0, 8'hFF);   // KBD writes ignored
    peek(2'd0, d); check("kbd_write_ignored", d, 8'h53);

    // Display write, drop, ack
    cpu_write(2'd2, 8'h8D);
    check("dsp_valid_set", {7'd0, dsp_valid}, 8'h01);
    check("dsp_data", {1'b0, dsp_data}, 8'h0D);
    peek(2'd2, d); check("dsp_read", d, 8'h8D);
    cpu_write(2'd2, 8'h41);
    peek(2'd3, d); check("dspcr_drop", d, 8'hC0);
    check("dsp_data_kept", {1'b0, dsp_data}, 8'h0D);
    dsp_ack = 1'b1;
    tick();
    dsp_ack = 1'b0;
    check("ack_clears", {7'd0, dsp_valid}, 8'h00);
    peek(2'd3, d); check("dspcr_idle_drop", d, 8'h40);
    cpu_write(2'd3, 8'h45);
    peek(2'd3, d); check("drop_cleared", d, 8'h05);

    // Ack coincident with write while IDLE: write wins; then timeout window
    dsp_ack = 1'b1;
    cpu_write(2'd2, 8'h31);
    dsp_ack = 1'b0;
    check("write_beats_ack", {7'd0, dsp_valid}, 8'h01);
    cnt = 1;
    while (dsp_valid && cnt < 100) begin
      tick();
      if (dsp_valid) cnt++;
    end
    check("timeout_cycles", 8'(cnt), 8'(TOUT));
    check("timeout_idle", {7'd0, dsp_valid}, 8'h00);

    // Ack while IDLE is ignored
    dsp_ack = 1'b1;
    tick();
    dsp_ack = 1'b0;
    peek(2'd2, d); check("idle_ack_ignored", d, 8'h31);

    // Case folding option
    push_key(7'h61);
    cpu_read(2'd0, d);
`ifdef APPLE1_PIA_UPCASE_EN
    check("upcase_a", d, 8'hC1);
`else
    check("verbatim_a", d, 8'hE1);
`endif
    push_key(7'h7B);
    cpu_read(2'd0, d); check("brace_verbatim", d, 8'hFB);

    // Asynchronous reset mid-transfer
    cpu_write(2'd2, 8'h42);
    push_key(7'h44);
    #10 rst = 1'b1;
    #1;
    check("rst_dsp_valid", {7'd0, dsp_valid}, 8'h00);
    peek(2'd1, d); check("rst_fifo_empty", d, 8'h00);
    peek(2'd0, d); check("rst_kbd", d, 8'h00);
    check("rst_key_ready", {7'd0, key_ready}, 8'h01);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
